// File: rtl/mem_pkg.sv
// Shared memory-side definitions: access size codes, size masks and the
// store-buffer entry layout.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Entries are stored at the widest supported width; narrower instances truncate on read.
    localparam int unsigned MAX_AW = 64;
    localparam int unsigned MAX_DW = 64;

    typedef struct packed {
        logic [MAX_AW-1:0] addr;
        logic [MAX_DW-1:0] data;
        logic [1:0]        size;
        logic              valid;
    } sb_entry_t;

    function automatic logic [MAX_DW-1:0] size_mask(input logic [1:0] size);
        logic [MAX_DW-1:0] mask;
        case (size)
            SZ_B:    mask = MAX_DW'(64'h0000_0000_0000_00ff);
            SZ_H:    mask = MAX_DW'(64'h0000_0000_0000_ffff);
            SZ_W:    mask = MAX_DW'(64'h0000_0000_ffff_ffff);
            default: mask = '1;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-facing store/load handshake plus the data_memory write/read port
// of the store buffer.
interface store_buffer_if #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
) ();

    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [1:0]    st_size;

    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [1:0]    ld_size;
    logic          ld_fwd;
    logic [DW-1:0] ld_fwd_data;
    logic          ld_stall;

    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [1:0]    mem_write;
    logic          mem_we;
    logic          mem_read;

    logic          empty;
    logic          full;

    modport master (
        output st_valid, st_addr, st_data, st_size, ld_req, ld_addr, ld_size,
        input  st_ready, ld_fwd, ld_fwd_data, ld_stall,
        input  mem_address, mem_write_data, mem_write, mem_we, mem_read, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, ld_req, ld_addr, ld_size,
        output st_ready, ld_fwd, ld_fwd_data, ld_stall,
        output mem_address, mem_write_data, mem_write, mem_we, mem_read, empty, full
    );

endinterface

// File: rtl/sb_match.sv
// Combinational youngest-overlap finder: scans entries oldest to youngest from
// head so the last overlapping entry seen is the youngest.
module sb_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 64,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic [PW-1:0]            head,
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0][AW-1:0] addr,
    input  logic [DEPTH-1:0][1:0]    size,
    input  logic [AW-1:0]            ld_addr,
    input  logic [1:0]               ld_size,
    output logic [PW-1:0]            hit_idx,
    output logic                     hit_exact,
    output logic                     hit_overlap
);

    logic [PW-1:0] idx;

    always_comb begin
        hit_idx     = '0;
        hit_overlap = 1'b0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && (addr[idx][AW-1:3] == ld_addr[AW-1:3])) begin
                hit_idx     = idx;
                hit_overlap = 1'b1;
            end
        end
        hit_exact = hit_overlap && (addr[hit_idx] == ld_addr) && (size[hit_idx] == ld_size);
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the pipeline and data_memory: queues stores,
// drains one per free port cycle, forwards exact-match loads, stalls partial overlaps.
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    store_buffer_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t     entry_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] mem_address_q;
    logic [DW-1:0] mem_write_data_q;
    logic [1:0]    mem_write_q;
    logic          mem_we_q;

    logic push, pop, is_full, is_empty;
    logic ld_fwd, ld_stall;

    logic [DEPTH-1:0]         m_valid;
    logic [DEPTH-1:0][AW-1:0] m_addr;
    logic [DEPTH-1:0][1:0]    m_size;
    logic [PW-1:0]            hit_idx;
    logic                     hit_exact, hit_overlap;

    always_comb begin
        m_valid = '0;
        m_addr  = '0;
        m_size  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = entry_q[i].valid;
            m_addr[i]  = AW'(entry_q[i].addr);
            m_size[i]  = entry_q[i].size;
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .head        (head_q),
        .valid       (m_valid),
        .addr        (m_addr),
        .size        (m_size),
        .ld_addr     (bus.ld_addr),
        .ld_size     (bus.ld_size),
        .hit_idx     (hit_idx),
        .hit_exact   (hit_exact),
        .hit_overlap (hit_overlap)
    );

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign push     = bus.st_valid & ~is_full;
    // The write port is free unless a load is using it; a stalled load frees it.
    assign pop      = ~is_empty & (~bus.ld_req | ld_stall);

    assign ld_fwd   = bus.ld_req & hit_exact;
    assign ld_stall = bus.ld_req & hit_overlap & ~hit_exact;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= '0;
            mem_we_q         <= 1'b0;
        end else begin
            if (push) begin
                entry_q[tail_q] <= '{addr:  MAX_AW'(bus.st_addr),
                                     data:  MAX_DW'(bus.st_data),
                                     size:  bus.st_size,
                                     valid: 1'b1};
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                entry_q[head_q].valid <= 1'b0;
                head_q           <= head_q + PW'(1);
                mem_address_q    <= AW'(entry_q[head_q].addr);
                mem_write_data_q <= DW'(entry_q[head_q].data);
                mem_write_q      <= entry_q[head_q].size;
                mem_we_q         <= 1'b1;
            end else begin
                mem_we_q <= 1'b0;
            end
            count_q <= count_d;
        end
    end

    assign bus.st_ready       = ~is_full;
    assign bus.full           = is_full;
    assign bus.empty          = is_empty;
    assign bus.ld_fwd         = ld_fwd;
    assign bus.ld_stall       = ld_stall;
    assign bus.ld_fwd_data    = ld_fwd ? DW'(entry_q[hit_idx].data & size_mask(bus.ld_size)) : '0;
    assign bus.mem_read       = bus.ld_req & ~ld_fwd & ~ld_stall;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_we         = mem_we_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain, fill/backpressure, forwarding,
// youngest-match, partial-overlap stall and asynchronous reset.
module tb_store_buffer;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    store_buffer_if #(.AW(64), .DW(64)) sb ();

    store_buffer #(
        .DEPTH (4),
        .AW    (64),
        .DW    (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic v, input logic [63:0] a, input logic [63:0] d,
                      input logic [1:0] s);
        sb.st_valid = v;
        sb.st_addr  = a;
        sb.st_data  = d;
        sb.st_size  = s;
    endtask

    task automatic ld(input logic r, input logic [63:0] a, input logic [1:0] s);
        sb.ld_req  = r;
        sb.ld_addr = a;
        sb.ld_size = s;
    endtask

    initial begin
        st(1'b0, 64'h0, 64'h0, SZ_B);
        ld(1'b0, 64'h0, SZ_B);
        #1;
        chk("rst_empty", 64'(sb.empty), 64'd1);
        chk("rst_st_ready", 64'(sb.st_ready), 64'd1);
        chk("rst_full", 64'(sb.full), 64'd0);
        chk("rst_mem_we", 64'(sb.mem_we), 64'd0);
        chk("rst_mem_address", sb.mem_address, 64'h0);
        chk("rst_mem_write", 64'(sb.mem_write), 64'd0);
        chk("rst_ld_fwd", 64'(sb.ld_fwd), 64'd0);
        chk("rst_ld_stall", 64'(sb.ld_stall), 64'd0);
        chk("rst_mem_read", 64'(sb.mem_read), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single store drains the cycle after it is enqueued.
        st(1'b1, 64'h100, 64'h1122334455667788, SZ_D);
        tick();
        st(1'b0, 64'h0, 64'h0, SZ_B);
        chk("t1_not_empty", 64'(sb.empty), 64'd0);
        chk("t1_we_before", 64'(sb.mem_we), 64'd0);
        tick();
        chk("t1_we", 64'(sb.mem_we), 64'd1);
        chk("t1_addr", sb.mem_address, 64'h100);
        chk("t1_data", sb.mem_write_data, 64'h1122334455667788);
        chk("t1_size", 64'(sb.mem_write), 64'd3);
        chk("t1_empty", 64'(sb.empty), 64'd1);
        tick();
        chk("t1_we_off", 64'(sb.mem_we), 64'd0);
        chk("t1_addr_hold", sb.mem_address, 64'h100);

        // Fill while a non-overlapping load holds the port.
        ld(1'b1, 64'h800, SZ_D);
        for (int i = 0; i < 4; i++) begin
            st(1'b1, 64'h1000 + 64'(8 * i), 64'(i + 1), SZ_D);
            tick();
        end
        #1;
        chk("t2_full", 64'(sb.full), 64'd1);
        chk("t2_st_ready", 64'(sb.st_ready), 64'd0);
        chk("t2_no_drain", 64'(sb.mem_we), 64'd0);
        chk("t2_mem_read", 64'(sb.mem_read), 64'd1);
        st(1'b1, 64'h1020, 64'h5, SZ_D);
        tick();
        chk("t2_still_full", 64'(sb.full), 64'd1);
        st(1'b0, 64'h0, 64'h0, SZ_B);
        ld(1'b0, 64'h0, SZ_B);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t2_we%0d", i), 64'(sb.mem_we), 64'd1);
            chk($sformatf("t2_addr%0d", i), sb.mem_address, 64'h1000 + 64'(8 * i));
            chk($sformatf("t2_data%0d", i), sb.mem_write_data, 64'(i + 1));
            if (i == 0) chk("t2_ready_again", 64'(sb.st_ready), 64'd1);
        end
        chk("t2_empty", 64'(sb.empty), 64'd1);
        tick();
        chk("t2_fifth_ignored", 64'(sb.mem_we), 64'd0);

        // Exact match forwards, masked to the load size.
        st(1'b1, 64'h208, 64'h12345678DEADBEEF, SZ_W);
        tick();
        st(1'b0, 64'h0, 64'h0, SZ_B);
        ld(1'b1, 64'h208, SZ_W);
        #1;
        chk("t3_fwd", 64'(sb.ld_fwd), 64'd1);
        chk("t3_fwd_data", sb.ld_fwd_data, 64'h00000000DEADBEEF);
        chk("t3_mem_read", 64'(sb.mem_read), 64'd0);
        chk("t3_stall", 64'(sb.ld_stall), 64'd0);
        tick();
        chk("t3_held", 64'(sb.mem_we), 64'd0);
        ld(1'b0, 64'h0, SZ_B);
        tick();
        chk("t3_drain_we", 64'(sb.mem_we), 64'd1);
        chk("t3_drain_addr", sb.mem_address, 64'h208);
        chk("t3_drain_size", 64'(sb.mem_write), 64'd2);

        // Youngest of two same-address stores wins; inexact youngest stalls.
        ld(1'b1, 64'h800, SZ_D);
        st(1'b1, 64'h40, 64'h11AA, SZ_B);
        tick();
        st(1'b1, 64'h40, 64'h22BB, SZ_B);
        tick();
        st(1'b0, 64'h0, 64'h0, SZ_B);
        ld(1'b1, 64'h40, SZ_B);
        #1;
        chk("t4_fwd", 64'(sb.ld_fwd), 64'd1);
        chk("t4_fwd_data", sb.ld_fwd_data, 64'hBB);
        chk("t4_no_stall", 64'(sb.ld_stall), 64'd0);
        ld(1'b1, 64'h41, SZ_B);
        #1;
        chk("t4_addr_stall", 64'(sb.ld_stall), 64'd1);
        chk("t4_addr_nofwd", 64'(sb.ld_fwd), 64'd0);
        chk("t4_addr_noread", 64'(sb.mem_read), 64'd0);
        ld(1'b1, 64'h40, SZ_H);
        #1;
        chk("t4_size_stall", 64'(sb.ld_stall), 64'd1);
        ld(1'b0, 64'h0, SZ_B);
        tick();
        chk("t4_drain0", sb.mem_write_data, 64'h11AA);
        tick();
        chk("t4_drain1", sb.mem_write_data, 64'h22BB);
        chk("t4_empty", 64'(sb.empty), 64'd1);

        // Partial overlap stalls until the covering store drains.
        st(1'b1, 64'h300, 64'hCAFEF00D12345678, SZ_D);
        tick();
        st(1'b0, 64'h0, 64'h0, SZ_B);
        ld(1'b1, 64'h302, SZ_H);
        #1;
        chk("t5_stall", 64'(sb.ld_stall), 64'd1);
        chk("t5_noread", 64'(sb.mem_read), 64'd0);
        tick();
        chk("t5_we", 64'(sb.mem_we), 64'd1);
        chk("t5_addr", sb.mem_address, 64'h300);
        chk("t5_unstall", 64'(sb.ld_stall), 64'd0);
        chk("t5_read", 64'(sb.mem_read), 64'd1);
        chk("t5_nofwd", 64'(sb.ld_fwd), 64'd0);
        ld(1'b0, 64'h0, SZ_B);
        tick();
        chk("t5_we_off", 64'(sb.mem_we), 64'd0);

        // Asynchronous reset mid-drain with three stores pending.
        ld(1'b1, 64'h800, SZ_D);
        for (int i = 0; i < 3; i++) begin
            st(1'b1, 64'h500 + 64'(8 * i), 64'(16 + i), SZ_D);
            tick();
        end
        st(1'b1, 64'h518, 64'h13, SZ_D);
        ld(1'b0, 64'h0, SZ_B);
        tick();
        st(1'b0, 64'h0, 64'h0, SZ_B);
        chk("t6_we_pre", 64'(sb.mem_we), 64'd1);
        chk("t6_addr_pre", sb.mem_address, 64'h500);
        chk("t6_not_empty", 64'(sb.empty), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", 64'(sb.mem_we), 64'd0);
        chk("t6_rst_empty", 64'(sb.empty), 64'd1);
        chk("t6_rst_ready", 64'(sb.st_ready), 64'd1);
        chk("t6_rst_addr", sb.mem_address, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_quiet%0d", i), 64'(sb.mem_we), 64'd0);
        end
        chk("t6_empty_after", 64'(sb.empty), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
